adv7393_video_out: RTL and testbench

- Final output stage of the ADV7393 AXI video pipe, directly downstream of the line fetcher/line buffer.
- Generates PAL 625i raster timing: 1888 ticks per line, 625 lines, two fields.
- Requests frame lines from upstream and consumes the compressed 64-bit pixel words (4 × {Y,CbCr}).
- Drives a 10-bit multiplexed CbCr/Y bus plus HSYNC/VSYNC/FIELD to the encoder, centring the frame inside the active area.

---
 rtl/adv7393_video_out_pkg.sv | 46 ++++
 rtl/adv7393_video_out_timing_gen.sv | 89 ++++++++
 rtl/adv7393_video_out.sv | 107 ++++++++++
 tb/tb_adv7393_video_out.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/adv7393_video_out_pkg.sv
// Shared types and PAL 625i timing constants for the ADV7393 output stage.
package adv7393_video_out_pkg;

  localparam int PAL_LINE_LEN_BLANK_T = 352;
  localparam int PAL_LINE_LEN_ACT_T   = 1536;
  localparam int PAL_LINES            = 625;
  localparam int PAL_FIELD_CHANGE     = 313;
  localparam int PAL_F0_ACT_START     = 23;
  localparam int PAL_F1_ACT_START     = 336;
  localparam int PAL_ACT_LINES_FIELD  = 288;
  localparam int PAL_HSYNC_W          = 4;
  localparam int PAL_VSYNC_LINES      = 3;

  localparam int IN_DWIDTH  = 64;
  localparam int OUT_DWIDTH = 10;

  localparam logic [7:0] BLANK_Y = 8'h00;
  localparam logic [7:0] BLANK_C = 8'h00;

  typedef struct packed {
    logic [7:0] y;
    logic [7:0] c;
  } pixel_t;

  // Element i sits at bits [16i +: 16] of the compressed word.
  typedef pixel_t [3:0] pixel_stored_t;

  typedef struct packed {
    logic [10:0]        h_cnt;
    logic [9:0]         v_cnt;
    logic               field;
    logic               hsync_n;
    logic               vsync_n;
    logic               visible_line;
    logic               visible_pix;
    logic               phase;
    logic signed [10:0] fl;
    logic [9:0]         p;
    logic [9:0]         q;
  } raster_pos_t;

  function automatic logic [OUT_DWIDTH-1:0] out_code(input logic [7:0] b);
    return {b, 2'b00};
  endfunction

endpackage

// File: rtl/adv7393_video_out_timing_gen.sv
// Raster counters, sync decode, frame-latched config and per-tick position
// (frame line / pixel mapping of the centred picture).
module adv7393_timing_gen
  import adv7393_video_out_pkg::*;
#(
  parameter int LINE_LEN_BLANK_T = PAL_LINE_LEN_BLANK_T,
  parameter int LINE_LEN_ACT_T   = PAL_LINE_LEN_ACT_T,
  parameter int LINES            = PAL_LINES,
  parameter int FIELD_CHANGE     = PAL_FIELD_CHANGE,
  parameter int F0_ACT_START     = PAL_F0_ACT_START,
  parameter int F1_ACT_START     = PAL_F1_ACT_START,
  parameter int ACT_LINES_FIELD  = PAL_ACT_LINES_FIELD,
  parameter int HSYNC_W          = PAL_HSYNC_W,
  parameter int VSYNC_LINES      = PAL_VSYNC_LINES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] cfg_lines,
  input  logic [31:0] cfg_line_length,
  output raster_pos_t pos
);

  localparam int H_TOTAL    = LINE_LEN_BLANK_T + LINE_LEN_ACT_T;
  localparam int ACT_PIX    = LINE_LEN_ACT_T / 2;
  localparam int ACT_HEIGHT = 2 * ACT_LINES_FIELD;

  logic [10:0] h_cnt;
  logic [9:0]  v_cnt;
  logic [9:0]  lines_sh;
  logic [9:0]  len_sh;

  logic unused_cfg_hi;
  assign unused_cfg_hi = ^{cfg_lines[31:10], cfg_line_length[31:10]};

  always_ff @(posedge clk) begin
    if (rst) begin
      h_cnt    <= '0;
      v_cnt    <= '0;
      lines_sh <= '0;
      len_sh   <= '0;
    end else begin
      // Geometry only changes on a frame boundary so a frame is never torn.
      if (h_cnt == '0 && v_cnt == '0) begin
        lines_sh <= cfg_lines[9:0];
        len_sh   <= cfg_line_length[9:0];
      end
      if (h_cnt == 11'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == 10'(LINES - 1)) ? '0 : v_cnt + 10'd1;
      end else begin
        h_cnt <= h_cnt + 11'd1;
      end
    end
  end

  logic               fld;
  logic [9:0]         a;
  logic [9:0]         vstart;
  logic [9:0]         hoff;
  logic [10:0]        h_act;
  logic signed [10:0] fl;

  always_comb begin
    fld    = (v_cnt >= 10'(FIELD_CHANGE));
    a      = v_cnt - (fld ? 10'(F1_ACT_START) : 10'(F0_ACT_START));
    vstart = (10'(ACT_HEIGHT) - lines_sh) >> 1;
    hoff   = (10'(ACT_PIX) - len_sh) >> 1;
    // Lines before the field's first active line wrap a to a large value,
    // so the a < ACT_LINES_FIELD test rejects them before fl matters.
    fl     = $signed({a, fld}) - $signed({1'b0, vstart});
    h_act  = h_cnt - 11'(LINE_LEN_BLANK_T);

    pos.h_cnt        = h_cnt;
    pos.v_cnt        = v_cnt;
    pos.field        = fld;
    pos.hsync_n      = !(h_cnt < 11'(HSYNC_W));
    pos.vsync_n      = !((v_cnt < 10'(VSYNC_LINES)) ||
                         (fld && (v_cnt < 10'(FIELD_CHANGE + VSYNC_LINES))));
    pos.visible_line = (a < 10'(ACT_LINES_FIELD)) && !fl[10] &&
                       (fl < $signed({1'b0, lines_sh}));
    pos.fl           = fl;
    pos.p            = h_act[10:1];
    pos.phase        = h_act[0];
    pos.q            = h_act[10:1] - hoff;
    pos.visible_pix  = pos.visible_line && (h_cnt >= 11'(LINE_LEN_BLANK_T)) &&
                       (h_act[10:1] >= hoff) && (pos.q < len_sh);
  end

endmodule

// File: rtl/adv7393_video_out.sv
// ADV7393 output stage: line requests, pixel word consumption and the
// registered CbCr/Y multiplexed bus with syncs.
module adv7393_video_out
  import adv7393_video_out_pkg::*;
#(
  parameter int LINE_LEN_BLANK_T = PAL_LINE_LEN_BLANK_T,
  parameter int LINE_LEN_ACT_T   = PAL_LINE_LEN_ACT_T,
  parameter int LINES            = PAL_LINES,
  parameter int FIELD_CHANGE     = PAL_FIELD_CHANGE,
  parameter int F0_ACT_START     = PAL_F0_ACT_START,
  parameter int F1_ACT_START     = PAL_F1_ACT_START,
  parameter int ACT_LINES_FIELD  = PAL_ACT_LINES_FIELD,
  parameter int HSYNC_W          = PAL_HSYNC_W,
  parameter int VSYNC_LINES      = PAL_VSYNC_LINES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [31:0]           cfg_lines,
  input  logic [31:0]           cfg_line_length,
  output logic                  line_req,
  output logic [9:0]            line_idx,
  input  logic [IN_DWIDTH-1:0]  s_tdata,
  input  logic                  s_tvalid,
  output logic                  s_tready,
  output logic [OUT_DWIDTH-1:0] dout,
  output logic                  hsync_n,
  output logic                  vsync_n,
  output logic                  field,
  output logic                  underflow,
  input  logic                  underflow_clr
);

  raster_pos_t pos;

  adv7393_timing_gen #(
    .LINE_LEN_BLANK_T (LINE_LEN_BLANK_T),
    .LINE_LEN_ACT_T   (LINE_LEN_ACT_T),
    .LINES            (LINES),
    .FIELD_CHANGE     (FIELD_CHANGE),
    .F0_ACT_START     (F0_ACT_START),
    .F1_ACT_START     (F1_ACT_START),
    .ACT_LINES_FIELD  (ACT_LINES_FIELD),
    .HSYNC_W          (HSYNC_W),
    .VSYNC_LINES      (VSYNC_LINES)
  ) u_timing (
    .clk             (clk),
    .rst             (rst),
    .cfg_lines       (cfg_lines),
    .cfg_line_length (cfg_line_length),
    .pos             (pos)
  );

  logic unused_pos;
  assign unused_pos = ^{pos.v_cnt, pos.p, pos.fl[10], pos.q[9:2]};

  pixel_stored_t hold_word;
  pixel_stored_t cur_word;
  logic          hold_ok;
  logic          cur_ok;
  logic          grp_start;
  pixel_t        cur_px;
  logic [7:0]    out_byte;

  always_comb begin
    grp_start = pos.visible_pix && !pos.phase && (pos.q[1:0] == 2'd0);
    // The group's first tick is driven straight from the bus; the rest of
    // the group replays the word latched on that tick.
    cur_word  = grp_start ? pixel_stored_t'(s_tdata) : hold_word;
    cur_ok    = grp_start ? s_tvalid : hold_ok;
    cur_px    = cur_word[pos.q[1:0]];
    if (pos.visible_pix && cur_ok)
      out_byte = pos.phase ? cur_px.y : cur_px.c;
    else
      out_byte = pos.phase ? BLANK_Y : BLANK_C;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout      <= '0;
      hsync_n   <= 1'b1;
      vsync_n   <= 1'b1;
      field     <= 1'b0;
      line_req  <= 1'b0;
      line_idx  <= '0;
      s_tready  <= 1'b0;
      underflow <= 1'b0;
      hold_word <= '0;
      hold_ok   <= 1'b0;
    end else begin
      dout     <= out_code(out_byte);
      hsync_n  <= pos.hsync_n;
      vsync_n  <= pos.vsync_n;
      field    <= pos.field;
      line_req <= pos.visible_line && (pos.h_cnt == '0);
      if (pos.visible_line && (pos.h_cnt == '0))
        line_idx <= pos.fl[9:0];
      s_tready <= grp_start && s_tvalid;
      if (grp_start) begin
        hold_word <= pixel_stored_t'(s_tdata);
        hold_ok   <= s_tvalid;
      end
      // A fresh starvation event outranks a clear in the same cycle.
      underflow <= (grp_start && !s_tvalid) || (underflow && !underflow_clr);
    end
  end

endmodule

// File: tb/tb_adv7393_video_out.sv
// Random-stimulus bench: a shrunken raster checked every cycle against a
// cycle-count model, plus literal pins on both the shrunken and PAL instances.
module tb_adv7393_video_out;

  localparam int HB = 32, HA = 64, HT = HB + HA, NL = 25, FC = 13;
  localparam int F0 = 2, F1 = 15, ALF = 10, HSW = 4, VSL = 3;
  localparam int PIX = HA / 2, FR = HT * NL, NCYC = 40000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] cfg_lines = 32'd16;
  logic [31:0] cfg_line_length = 32'd24;
  logic [63:0] s_tdata = 64'h4433_6655_8877_1122;
  logic        s_tvalid = 1'b1;
  logic        underflow_clr = 1'b0;

  logic       line_req, s_tready, hsync_n, vsync_n, field, underflow;
  logic [9:0] line_idx, dout;
  logic       p_line_req, p_s_tready, p_hsync_n, p_vsync_n, p_field, p_underflow;
  logic [9:0] p_line_idx, p_dout;

  always #5 clk = ~clk;

  adv7393_video_out #(
    .LINE_LEN_BLANK_T(HB), .LINE_LEN_ACT_T(HA), .LINES(NL), .FIELD_CHANGE(FC),
    .F0_ACT_START(F0), .F1_ACT_START(F1), .ACT_LINES_FIELD(ALF),
    .HSYNC_W(HSW), .VSYNC_LINES(VSL)
  ) dut (
    .clk(clk), .rst(rst), .cfg_lines(cfg_lines), .cfg_line_length(cfg_line_length),
    .line_req(line_req), .line_idx(line_idx), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .dout(dout), .hsync_n(hsync_n), .vsync_n(vsync_n),
    .field(field), .underflow(underflow), .underflow_clr(underflow_clr)
  );

  adv7393_video_out pal (
    .clk(clk), .rst(rst), .cfg_lines(cfg_lines), .cfg_line_length(cfg_line_length),
    .line_req(p_line_req), .line_idx(p_line_idx), .s_tdata(s_tdata), .s_tvalid(s_tvalid),
    .s_tready(p_s_tready), .dout(p_dout), .hsync_n(p_hsync_n), .vsync_n(p_vsync_n),
    .field(p_field), .underflow(p_underflow), .underflow_clr(underflow_clr)
  );

  typedef struct {
    int         t;
    logic [9:0] dout;
    logic       hs, vs, fld, req, rdy, uf;
    int         idx;
  } exp_t;

  exp_t        e_cur, e_nxt;
  int          m_t = 0, m_lines = 0, m_len = 0;
  logic        m_uf = 1'b0, m_ok = 1'b0;
  logic [63:0] m_word = '0;
  int          checks = 0, errors = 0, rdy_cnt = 0;
  bit          chk_en = 0, lit_en = 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0d got %0h want %0h", name, e_cur.t, act, exp);
    end
  endtask

  // Model: the output for a raster position follows from the cycle count
  // since reset; the geometry is the config captured at each frame start.
  task automatic model_step();
    int h, v, a, fl, vstart, hoff, p, q, k;
    bit fld, vl, vp, ph, start;
    logic [15:0] px;
    logic [7:0]  b;
    if (rst) begin
      e_nxt.t = -1; e_nxt.dout = '0; e_nxt.hs = 1; e_nxt.vs = 1; e_nxt.fld = 0;
      e_nxt.req = 0; e_nxt.idx = 0; e_nxt.rdy = 0; e_nxt.uf = 0;
      m_t = 0; m_lines = 0; m_len = 0; m_uf = 0; m_ok = 0; m_word = '0;
    end else begin
      h = m_t % HT;
      v = (m_t / HT) % NL;
      fld = (v >= FC);
      a = v - (fld ? F1 : F0);
      vstart = (2 * ALF - m_lines) / 2;
      fl = 2 * a + int'(fld) - vstart;
      vl = (a >= 0) && (a < ALF) && (fl >= 0) && (fl < m_lines);
      hoff = (PIX - m_len) / 2;
      p = (h >= HB) ? (h - HB) / 2 : 0;
      ph = (h >= HB) ? ((h - HB) % 2 == 1) : 0;
      q = p - hoff;
      vp = vl && (h >= HB) && (q >= 0) && (q < m_len);
      start = vp && !ph && (q % 4 == 0);
      if (start) begin
        m_word = s_tdata;
        m_ok = s_tvalid;
      end
      k = vp ? q % 4 : 0;
      px = m_word[16*k +: 16];
      b = (vp && m_ok) ? (ph ? px[15:8] : px[7:0]) : 8'h00;
      e_nxt.t = m_t;
      e_nxt.dout = {b, 2'b00};
      e_nxt.hs = (h >= HSW);
      e_nxt.vs = !((v < VSL) || (v >= FC && v < FC + VSL));
      e_nxt.fld = fld;
      e_nxt.req = vl && (h == 0);
      e_nxt.idx = fl;
      e_nxt.rdy = start && s_tvalid;
      e_nxt.uf = (start && !s_tvalid) || (m_uf && !underflow_clr);
      m_uf = e_nxt.uf;
      if (m_t % FR == 0) begin
        m_lines = int'(cfg_lines);
        m_len = int'(cfg_line_length);
      end
      m_t++;
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("dout", dout, e_cur.dout);
      chk("hsync_n", hsync_n, e_cur.hs);
      chk("vsync_n", vsync_n, e_cur.vs);
      chk("field", field, e_cur.fld);
      chk("line_req", line_req, e_cur.req);
      if (e_cur.req) chk("line_idx", line_idx, 64'(e_cur.idx[9:0]));
      chk("s_tready", s_tready, e_cur.rdy);
      chk("underflow", underflow, e_cur.uf);
      if (lit_en) begin
        if (e_cur.t < 0) begin
          chk("rst_dout", dout, 0);          chk("rst_hsync", hsync_n, 1);
          chk("rst_vsync", vsync_n, 1);      chk("rst_field", field, 0);
          chk("rst_req", line_req, 0);       chk("rst_rdy", s_tready, 0);
          chk("rst_uf", underflow, 0);       chk("pal_rst_dout", p_dout, 0);
          chk("pal_rst_hs", p_hsync_n, 1);   chk("pal_rst_vs", p_vsync_n, 1);
          chk("pal_rst_req", p_line_req, 0); chk("pal_rst_rdy", p_s_tready, 0);
          chk("pal_rst_uf", p_underflow, 0); chk("pal_rst_fld", p_field, 0);
          chk("pal_rst_idx", p_line_idx, 0);
        end
        if (e_cur.t >= 288 && e_cur.t < 384 && s_tready) rdy_cnt++;
        case (e_cur.t)
          0:    begin chk("lit_hs_lo", hsync_n, 0); chk("pal_hs_lo", p_hsync_n, 0); end
          3:    begin chk("lit_hs_lo3", hsync_n, 0); chk("pal_hs_lo3", p_hsync_n, 0); end
          4:    begin chk("lit_hs_hi", hsync_n, 1); chk("pal_hs_hi", p_hsync_n, 1); end
          287:  chk("lit_no_req", line_req, 0);
          288:  begin chk("lit_first_req", line_req, 1); chk("lit_first_idx", line_idx, 0); end
          328:  chk("lit_first_c", dout, 10'h088);
          329:  chk("lit_first_y", dout, 10'h044);
          384:  chk("lit_rdy_per_line", rdy_cnt, 6);
          423:  chk("lit_uf_before", underflow, 0);
          424:  begin chk("lit_uf_set", underflow, 1); chk("lit_uf_blank", dout, 0); end
          431:  chk("lit_uf_blank_end", dout, 0);
          432:  chk("lit_resume", dout, 10'h088);
          499:  chk("lit_uf_sticky", underflow, 1);
          500:  chk("lit_uf_clr", underflow, 0);
          1000: chk("pal_blank_dout", p_dout, 0);
          1247: chk("lit_field0", field, 0);
          1248: chk("lit_field1", field, 1);
          1887: chk("pal_hs_end", p_hsync_n, 1);
          1888: chk("pal_line_period", p_hsync_n, 0);
          1892: chk("pal_hs_width", p_hsync_n, 1);
          5663: chk("pal_vs_lo", p_vsync_n, 0);
          5664: begin chk("pal_vs_hi", p_vsync_n, 1); chk("pal_field0", p_field, 0); end
          default: ;
        endcase
      end
    end
  end

  initial begin
    int rst_left;
    rst_left = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(posedge clk);
      #1;
      e_cur = e_nxt;
      chk_en = (cyc > 0);
      if (cyc > 7000) lit_en = 0;
      if (cyc < 5) rst = 1'b1;
      else if (rst_left > 0) begin
        rst = 1'b1;
        rst_left--;
      end else if (cyc == 20000 || (cyc > 8000 && $urandom_range(0, 2499) == 0)) begin
        rst = 1'b1;
        rst_left = int'($urandom_range(0, 2));
      end else rst = 1'b0;
      if (cyc < 3000) begin
        s_tvalid = (m_t != 424);
        underflow_clr = (m_t == 500);
      end else begin
        s_tdata = {$urandom, $urandom};
        s_tvalid = ($urandom_range(0, 15) != 0);
        underflow_clr = ($urandom_range(0, 63) == 0);
        if ($urandom_range(0, 399) == 0) begin
          cfg_lines = 2 * $urandom_range(1, ALF);
          cfg_line_length = 4 * $urandom_range(1, PIX / 4);
        end
      end
      model_step();
    end
    @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
